// File: rtl/cpu_step_gater.sv
// Single-step clock-enable gate for the 8080 core: free run, cycle step or instruction step.
// Optional BREAKPOINT_EN adds an address breakpoint (addr, bp_addr, bp_valid, bp_hit).
//   state    | meaning
//   ST_RUN   | free run, every ce_in passes
//   ST_HALT  | CPU frozen, waiting for step_req or pending request
//   ST_CYC   | releasing exactly one ce_in
//   ST_INSTR | releasing ce_in until the next fetch or watchdog expiry
module cpu_step_gater #(
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 64
) (
   input  logic             clk24,
   input  logic             reset_n,
   input  logic             ce_in,
   input  logic             step_mode,
   input  logic             step_req,
   input  logic             step_unit,
   input  logic             m1,
`ifdef BREAKPOINT_EN
   input  logic [15:0]      addr,
   input  logic [15:0]      bp_addr,
   input  logic             bp_valid,
   output logic             bp_hit,
`endif
   output logic             ce_out,
   output logic             halted,
   output logic             step_done,
   output logic             step_timeout,
   output logic [CNT_W-1:0] step_count
);

   localparam int CYC_W = $clog2(MAX_CYCLES + 1);
   localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(MAX_CYCLES);

   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_CYC, ST_INSTR} state_t;

   state_t           r_state, w_state_nx;
   logic             r_pending, w_pending_nx;
   logic [CYC_W-1:0] r_cyc, w_cyc_nx, w_cyc_inc;
   logic             r_step_done, w_done_nx;
   logic             r_timeout, w_timeout_nx;
   logic [CNT_W-1:0] r_count;
   logic             w_pass;
`ifdef BREAKPOINT_EN
   logic             r_bp_hit, w_bp_hit_nx;
   logic             r_bp_armed, w_bp_armed_nx;
`endif

   always_comb begin
      w_state_nx   = r_state;
      w_pending_nx = r_pending;
      w_cyc_nx     = r_cyc;
      w_done_nx    = 1'b0;
      w_timeout_nx = r_timeout;
      w_pass       = 1'b0;
      w_cyc_inc    = r_cyc + 1'b1;
`ifdef BREAKPOINT_EN
      w_bp_hit_nx   = r_bp_hit;
      w_bp_armed_nx = r_bp_armed;
`endif
      case (r_state)
         ST_RUN: begin
            w_pass       = 1'b1;
            w_pending_nx = 1'b0;
            if (step_mode) w_state_nx = ST_HALT;
`ifdef BREAKPOINT_EN
            if (ce_in && m1 && bp_valid && (addr == bp_addr)) begin
               w_pass        = 1'b0;
               w_state_nx    = ST_HALT;
               w_bp_hit_nx   = 1'b1;
               w_bp_armed_nx = 1'b0;
            end
`endif
         end
         ST_HALT: begin
            if (!step_mode) begin
`ifdef BREAKPOINT_EN
               // a breakpoint hit in free run holds until step_mode toggles, avoiding an instant re-hit
               if (!r_bp_hit || r_bp_armed) begin
                  w_state_nx    = ST_RUN;
                  w_bp_hit_nx   = 1'b0;
                  w_bp_armed_nx = 1'b0;
               end
`else
               w_state_nx = ST_RUN;
`endif
               w_pending_nx = 1'b0;
            end else begin
`ifdef BREAKPOINT_EN
               if (r_bp_hit) w_bp_armed_nx = 1'b1;
`endif
               if (step_req || r_pending) begin
                  w_pending_nx = 1'b0;
                  w_timeout_nx = 1'b0;
                  w_cyc_nx     = '0;
                  w_state_nx   = step_unit ? ST_INSTR : ST_CYC;
`ifdef BREAKPOINT_EN
                  w_bp_hit_nx   = 1'b0;
                  w_bp_armed_nx = 1'b0;
`endif
               end
            end
         end
         ST_CYC: begin
            w_pass = 1'b1;
            if (!step_mode) begin
               w_state_nx   = ST_RUN;
               w_pending_nx = 1'b0;
            end else begin
               if (step_req) w_pending_nx = 1'b1;
               if (ce_in) begin
                  w_state_nx = ST_HALT;
                  w_done_nx  = 1'b1;
               end
            end
         end
         ST_INSTR: begin
            // a fetch after the first released cycle belongs to the next instruction
            w_pass = !(m1 && (r_cyc != '0));
            if (!step_mode) begin
               w_state_nx   = ST_RUN;
               w_pending_nx = 1'b0;
            end else begin
               if (step_req) w_pending_nx = 1'b1;
               if (ce_in) begin
                  if (m1 && (r_cyc != '0)) begin
                     w_state_nx = ST_HALT;
                     w_done_nx  = 1'b1;
                  end else begin
                     w_cyc_nx = w_cyc_inc;
                     if (w_cyc_inc == CYC_MAX) begin
                        w_state_nx   = ST_HALT;
                        w_done_nx    = 1'b1;
                        w_timeout_nx = 1'b1;
                     end
                  end
               end
            end
         end
         default: w_state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge clk24 or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_RUN;
         r_pending   <= 1'b0;
         r_cyc       <= '0;
         r_step_done <= 1'b0;
         r_timeout   <= 1'b0;
         r_count     <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_pending   <= w_pending_nx;
         r_cyc       <= w_cyc_nx;
         r_step_done <= w_done_nx;
         r_timeout   <= w_timeout_nx;
         if (w_done_nx) r_count <= r_count + 1'b1;
      end
   end

`ifdef BREAKPOINT_EN
   always_ff @(posedge clk24 or negedge reset_n) begin
      if (!reset_n) begin
         r_bp_hit   <= 1'b0;
         r_bp_armed <= 1'b0;
      end else begin
         r_bp_hit   <= w_bp_hit_nx;
         r_bp_armed <= w_bp_armed_nx;
      end
   end
   assign bp_hit = r_bp_hit;
`endif

   // reset_n gate keeps ce_out low while reset is held, even though RUN passes
   assign ce_out       = ce_in & w_pass & reset_n;
   assign halted       = (r_state == ST_HALT);
   assign step_done    = r_step_done;
   assign step_timeout = r_timeout;
   assign step_count   = r_count;

endmodule
